// File: rtl/i2c_target_regfile.sv
// I2C target with one fixed device address and a pointer-addressed byte register space.
// Register storage lives outside: writes leave through a strobe port, reads come back combinationally.
module i2c_target_regfile #(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             rd_en,
  output logic             busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWr, StWrAck, StRd, StRdAck, StWaitStop
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             rw_q, rw_d;
  logic             mack_q, mack_d;
  logic             sda_oe_d, wr_en_d, rd_en_d, busy_d;
  logic [PTR_W-1:0] wr_addr_d;
  logic [7:0]       wr_data_d;

  // Sync flops reset to 1 so the idle bus produces no spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign ptr_inc = (32'(ptr_q) == NUM_REGS - 1) ? '0 : ptr_q + 1'b1;
  assign rd_addr = ptr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = StAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWr: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shreg_d = {shreg_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              if (shreg_q[7:1] == DEV_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shreg_q[0];
                state_d  = StAddrAck;
              end else begin
                state_d = StWaitStop;
              end
            end else if (state_q == StPtr) begin
              if (32'(shreg_q) < NUM_REGS) begin
                ptr_d    = shreg_q[PTR_W-1:0];
                sda_oe_d = 1'b1;
                state_d  = StPtrAck;
              end else begin
                state_d = StWaitStop;
              end
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shreg_q;
              ptr_d     = ptr_inc;
              sda_oe_d  = 1'b1;
              state_d   = StWrAck;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              shreg_d  = rd_data;
              rd_en_d  = 1'b1;
              sda_oe_d = ~rd_data[7];
              cnt_d    = 4'd1;
              mack_d   = 1'b0;
              state_d  = StRd;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StPtr;
            end
          end
        end
        StPtrAck, StWrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWr;
          end
        end
        StRd: begin
          // shreg[7] always holds the bit currently on the bus
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d = ~shreg_q[6];
              shreg_d  = {shreg_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            ptr_d  = ptr_inc;
            mack_d = ~sda_s;
            if (sda_s) state_d = StWaitStop;
          end else if (scl_fall && mack_q) begin
            shreg_d  = rd_data;
            rd_en_d  = 1'b1;
            sda_oe_d = ~rd_data[7];
            cnt_d    = 4'd1;
            mack_d   = 1'b0;
            state_d  = StRd;
          end
        end
        StIdle, StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      mack_q  <= 1'b0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      mack_q  <= mack_d;
      sda_oe  <= sda_oe_d;
      wr_en   <= wr_en_d;
      rd_en   <= rd_en_d;
      busy    <= busy_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, open-drain bus model and a
// strobe scoreboard fed by the stimulus and drained by a monitor.
module tb_i2c_target_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       sda_line;
  logic       sda_oe, wr_en, rd_en, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  assign sda_line = ~(m_low | sda_oe);
  assign rd_data  = {4'h0, rd_addr};

  always #5 clk = ~clk;

  i2c_target_regfile #(.DEV_ADDR(7'h50), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_en(rd_en), .busy(busy)
  );

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t        exp_wr[$];
  logic [3:0] exp_rd[$];
  wr_t        e_wr;
  logic [3:0] e_rd;
  int nvec = 0, nerr = 0;
  int wr_cnt = 0, rd_cnt = 0;
  bit oe_seen = 1'b0, busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected strobe whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (wr_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) check("unexpected wr_en", 1, 0);
        else begin
          e_wr = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e_wr.a));
          check("wr_data", 32'(wr_data), 32'(e_wr.d));
        end
      end
      if (rd_en) begin
        rd_cnt++;
        if (exp_rd.size() == 0) check("unexpected rd_en", 1, 0);
        else begin
          e_rd = exp_rd.pop_front();
          check("rd_en addr", 32'(rd_addr), 32'(e_rd));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Quarter SCL period: SCL runs at 1/40 of clk.
  task automatic q();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; q();
    scl = 1'b1;   q();
    m_low = 1'b1; q();
    scl = 1'b0;   q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; q();
    scl = 1'b1;   q();
    m_low = 1'b0; q();
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; q();
    scl = 1'b1;   q();
    b = sda_line; q();
    scl = 1'b0;   q();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         wr0, rd0;

    repeat (4) @(posedge clk);
    #1;
    check("reset sda_oe", 32'(sda_oe), 0);
    check("reset wr_en", 32'(wr_en), 0);
    check("reset rd_en", 32'(rd_en), 0);
    check("reset busy", 32'(busy), 0);
    check("reset ptr", 32'(rd_addr), 0);
    check("reset wr_addr/data", {20'h0, wr_addr, wr_data}, 0);
    rst = 1'b0;
    q();

    // Pointer write then two data bytes
    i2c_start();
    write_byte(8'hA0, a); check("t1 addr ack", 32'(a), 0);
    check("t1 busy", 32'(busy), 1);
    write_byte(8'h03, a); check("t1 ptr ack", 32'(a), 0);
    exp_wr.push_back('{a: 4'h3, d: 8'hA5});
    exp_wr.push_back('{a: 4'h4, d: 8'h5A});
    write_byte(8'hA5, a); check("t1 data0 ack", 32'(a), 0);
    write_byte(8'h5A, a); check("t1 data1 ack", 32'(a), 0);
    i2c_stop();
    q();
    check("t1 busy after stop", 32'(busy), 0);
    check("t1 ptr", 32'(rd_addr), 5);
    check("t1 wr count", 32'(wr_cnt), 2);

    // Pointer 0x0E, repeated START, read three bytes across the wrap
    i2c_start();
    write_byte(8'hA0, a); check("t2 addr ack", 32'(a), 0);
    write_byte(8'h0E, a); check("t2 ptr ack", 32'(a), 0);
    exp_rd.push_back(4'hE);
    exp_rd.push_back(4'hF);
    exp_rd.push_back(4'h0);
    i2c_start();
    write_byte(8'hA1, a); check("t2 raddr ack", 32'(a), 0);
    read_byte(d, 1'b0); check("t2 rd0", 32'(d), 32'h0E);
    read_byte(d, 1'b0); check("t2 rd1", 32'(d), 32'h0F);
    read_byte(d, 1'b1); check("t2 rd2", 32'(d), 32'h00);
    i2c_stop();
    q();
    check("t2 ptr", 32'(rd_addr), 1);
    check("t2 rd count", 32'(rd_cnt), 3);

    // Foreign address: target stays silent
    wr0 = wr_cnt; rd0 = rd_cnt;
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, a); check("t3 addr nack", 32'(a), 1);
    write_byte(8'h01, a);
    write_byte(8'h55, a);
    i2c_stop();
    q();
    check("t3 sda_oe seen", 32'(oe_seen), 0);
    check("t3 busy seen", 32'(busy_seen), 0);
    check("t3 strobes", 32'(wr_cnt - wr0 + rd_cnt - rd0), 0);

    // Out-of-range pointer
    wr0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("t4 addr ack", 32'(a), 0);
    write_byte(8'h10, a); check("t4 ptr nack", 32'(a), 1);
    write_byte(8'h33, a); check("t4 data ignored", 32'(a), 1);
    i2c_stop();
    q();
    check("t4 ptr unchanged", 32'(rd_addr), 1);
    check("t4 no wr_en", 32'(wr_cnt - wr0), 0);

    // STOP in the middle of a data byte, then a full transaction
    wr0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("t5 addr ack", 32'(a), 0);
    write_byte(8'h07, a); check("t5 ptr ack", 32'(a), 0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    q();
    check("t5 abort no wr_en", 32'(wr_cnt - wr0), 0);
    check("t5 abort ptr", 32'(rd_addr), 7);
    check("t5 abort busy", 32'(busy), 0);
    i2c_start();
    write_byte(8'hA0, a); check("t5 re addr ack", 32'(a), 0);
    write_byte(8'h02, a); check("t5 re ptr ack", 32'(a), 0);
    exp_wr.push_back('{a: 4'h2, d: 8'hC3});
    write_byte(8'hC3, a); check("t5 re data ack", 32'(a), 0);
    i2c_stop();
    q();
    check("t5 ptr", 32'(rd_addr), 3);

    // Reset while the target drives a 0 data bit
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h05, a);
    exp_rd.push_back(4'h5);
    i2c_start();
    write_byte(8'hA1, a); check("t6 raddr ack", 32'(a), 0);
    check("t6 driving bit7=0", 32'(sda_oe), 1);
    check("t6 busy before rst", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check("t6 sda_oe async clear", 32'(sda_oe), 0);
    check("t6 rst busy", 32'(busy), 0);
    check("t6 rst ptr", 32'(rd_addr), 0);
    check("t6 rst strobes", {30'h0, wr_en, rd_en}, 0);
    check("t6 rst wr_addr/data", {20'h0, wr_addr, wr_data}, 0);
    q();
    rst = 1'b0;
    q();
    i2c_stop();
    exp_rd.push_back(4'h0);
    i2c_start();
    write_byte(8'hA1, a); check("t6 post addr ack", 32'(a), 0);
    read_byte(d, 1'b1); check("t6 post rd", 32'(d), 32'h00);
    i2c_stop();
    q();
    check("t6 post ptr", 32'(rd_addr), 1);

    check("wr queue drained", 32'(exp_wr.size()), 0);
    check("rd queue drained", 32'(exp_rd.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
